// File: rtl/puf_eval_ctrl_pkg.sv
// puf_eval_ctrl_pkg: shared definitions for the arbiter-PUF evaluation controller.
// Holds the FSM state encoding and the default challenge width / settle time /
// evaluation count, which the Ethernet command decoder also relies on.
package puf_eval_ctrl_pkg;

    localparam int PUF_CW_DEF     = 64;
    localparam int PUF_SETTLE_DEF = 16;
    localparam int PUF_EVALS_DEF  = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOW    = 3'd1,
        ST_HIGH   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } puf_state_e;

endpackage

// File: rtl/puf_eval_ctrl_resp_sync.sv
// puf_resp_sync: two-flop synchronizer for the arbiter flop output.
// Ports:
//   clk   in  clock
//   reset in  synchronous active-high reset, clears both flops
//   d     in  asynchronous input
//   q     out synchronized output
module puf_resp_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences one arbiter-PUF evaluation per accepted challenge.
// The challenge is held on the PDL selects, the race is precharged (launch=0)
// and fired (launch=1) EVALS times, the synchronized arbiter output is sampled
// after each fire, and a majority-voted bit plus the count of ones is returned.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req_valid/ready request handshake; req_challenge captured on handshake
//   rsp_valid/ready response handshake; rsp_bit majority, rsp_ones count of '1'
//   puf_challenge   registered PDL select bus
//   puf_launch      registered race launch (0 precharge, 1 fire)
//   puf_resp        arbiter flop output, asynchronous to clk
//   busy            high whenever not IDLE
module puf_eval_ctrl
    import puf_eval_ctrl_pkg::*;
#(
    parameter  int CW     = PUF_CW_DEF,
    parameter  int SETTLE = PUF_SETTLE_DEF,
    parameter  int EVALS  = PUF_EVALS_DEF,
    localparam int CNT_W  = $clog2(EVALS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_challenge,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_bit,
    output logic [CNT_W-1:0] rsp_ones,
    output logic [CW-1:0]    puf_challenge,
    output logic             puf_launch,
    input  logic             puf_resp,
    output logic             busy
);

    localparam int PH_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVALS - 1);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(EVALS / 2);

    puf_state_e       state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] eval_q, eval_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CW-1:0]    chal_q, chal_d;
    logic             rsp_bit_q, rsp_bit_d;
    logic [CNT_W-1:0] rsp_ones_q, rsp_ones_d;
    logic             launch_q, launch_d;
    logic             resp_sync;

    puf_resp_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (puf_resp),
        .q     (resp_sync)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        eval_d     = eval_q;
        ones_d     = ones_q;
        chal_d     = chal_q;
        rsp_bit_d  = rsp_bit_q;
        rsp_ones_d = rsp_ones_q;
        // Launch follows the registered state, so the fire pulse on the PUF
        // side lags the HIGH state by one cycle and drops once SAMPLE has passed.
        launch_d   = (state_q == ST_HIGH);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    chal_d  = req_challenge;
                    phase_d = '0;
                    eval_d  = '0;
                    ones_d  = '0;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = ST_HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                ones_d = ones_q + CNT_W'(resp_sync);
                if (eval_q == EVAL_LAST) begin
                    rsp_ones_d = ones_d;
                    rsp_bit_d  = (ones_d > HALF);
                    state_d    = ST_DONE;
                end else begin
                    eval_d  = eval_q + 1'b1;
                    state_d = ST_LOW;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            eval_q     <= '0;
            ones_q     <= '0;
            chal_q     <= '0;
            rsp_bit_q  <= 1'b0;
            rsp_ones_q <= '0;
            launch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            eval_q     <= eval_d;
            ones_q     <= ones_d;
            chal_q     <= chal_d;
            rsp_bit_q  <= rsp_bit_d;
            rsp_ones_q <= rsp_ones_d;
            launch_q   <= launch_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign rsp_valid     = (state_q == ST_DONE);
    assign rsp_bit       = rsp_bit_q;
    assign rsp_ones      = rsp_ones_q;
    assign puf_challenge = chal_q;
    assign puf_launch    = launch_q;

endmodule
